// File: rtl/sw_pkg.sv
// Shared types for the stopwatch sequencer slice.
// Holds the FSM state encoding, control-mode encoding and the BCD time width.
package sw_pkg;

  localparam int TW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    SPLIT  = 2'd3
  } sw_state_e;

  typedef enum logic {
    MODE_SW    = 1'b0,
    MODE_STASH = 1'b1
  } sw_mode_e;

endpackage

// File: rtl/stopwatch_sequencer_if.sv
// Command/datapath bundle between debouncers, sequencer and Counter/Stash.
// master: drives cmd_* and time_reading; slave: the sequencer, drives the rest.
interface stopwatch_sequencer_if;
  import sw_pkg::*;

  logic          cmd_trig;
  logic          cmd_split;
  logic          cmd_sample;
  logic          cmd_toggle;
  logic [TW-1:0] time_reading;

  logic          init_regs;
  logic          count_enabled;
  logic          stash_wr;
  logic [TW-1:0] stash_data;
  logic          stash_next;
  logic          stash_full;
  logic          sample_drop;
  logic [TW-1:0] disp_time;
  logic          split_active;
  logic          control_mode;

  modport master (
    output cmd_trig, cmd_split,
    output cmd_sample, cmd_toggle,
    output time_reading,
    input  init_regs, count_enabled,
    input  stash_wr, stash_data,
    input  stash_next, stash_full,
    input  sample_drop, disp_time,
    input  split_active, control_mode
  );

  modport slave (
    input  cmd_trig, cmd_split,
    input  cmd_sample, cmd_toggle,
    input  time_reading,
    output init_regs, count_enabled,
    output stash_wr, stash_data,
    output stash_next, stash_full,
    output sample_drop, disp_time,
    output split_active, control_mode
  );

endinterface

// File: rtl/hold_timer.sv
// Split-hold down-counter: i_load arms it, i_en counts, o_expired at zero.
// Ports: clk, reset (async high), i_load, i_en, o_expired. CYCLES=0 never expires.
module hold_timer #(
  parameter int CYCLES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
  localparam logic [W-1:0] LOAD =
    (CYCLES > 0) ? W'(CYCLES - 1) : '0;
  localparam bit CAN_EXPIRE = (CYCLES > 0);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD;
    end else if (i_en && r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Expiry is only meaningful while counting and not being re-armed.
  assign o_expired = CAN_EXPIRE && i_en &&
                     !i_load && (r_cnt == '0);

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch controller: run/pause/split/clear FSM, trigger routing, Stash gating.
// Ports: clk, reset (async high), bus (slave modport of stopwatch_sequencer_if).
module stopwatch_sequencer
  import sw_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int HOLD_SEC = 3,
  parameter int DEPTH    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  stopwatch_sequencer_if.slave  bus
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  sw_state_e     r_state;
  sw_mode_e      r_mode;
  logic [OW-1:0] r_occ;
  logic [TW-1:0] r_snap;
  logic          r_init;
  logic          r_cen;
  logic          r_split;
  logic          r_wr;
  logic [TW-1:0] r_data;
  logic          r_next;
  logic          r_full;
  logic          r_drop;

  sw_state_e     w_nxt;
  logic          w_capture;
  logic          w_expired;
  logic          w_trig_fsm;
  logic          w_trig_stash;
  logic          w_push;
  logic [OW-1:0] w_occ_nxt;

  // Routing uses the mode held before any same-cycle toggle.
  assign w_trig_fsm   = bus.cmd_trig && (r_mode == MODE_SW);
  assign w_trig_stash = bus.cmd_trig && (r_mode == MODE_STASH);

  assign w_push    = bus.cmd_sample && (r_occ != FULL);
  assign w_occ_nxt = w_push ? r_occ + OW'(1) : r_occ;

  hold_timer #(
    .CYCLES (CLK_FREQ * HOLD_SEC)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_capture),
    .i_en      (r_state == SPLIT),
    .o_expired (w_expired)
  );

  always_comb begin
    w_nxt     = r_state;
    w_capture = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_trig_fsm) w_nxt = RUN;
      end
      RUN: begin
        if (w_trig_fsm) begin
          w_nxt = PAUSED;
        end else if (bus.cmd_split) begin
          w_nxt     = SPLIT;
          w_capture = 1'b1;
        end
      end
      SPLIT: begin
        if (w_trig_fsm) begin
          w_nxt = PAUSED;
        end else if (bus.cmd_split) begin
          w_capture = 1'b1;
        end else if (w_expired) begin
          w_nxt = RUN;
        end
      end
      PAUSED: begin
        if (w_trig_fsm) begin
          w_nxt = RUN;
        end else if (bus.cmd_split) begin
          w_nxt = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_mode  <= MODE_SW;
      r_occ   <= '0;
      r_snap  <= '0;
      r_init  <= 1'b1;
      r_cen   <= 1'b0;
      r_split <= 1'b0;
      r_wr    <= 1'b0;
      r_data  <= '0;
      r_next  <= 1'b0;
      r_full  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_init  <= (w_nxt == IDLE);
      r_cen   <= (w_nxt == RUN) || (w_nxt == SPLIT);
      r_split <= (w_nxt == SPLIT);
      if (w_capture) r_snap <= bus.time_reading;
      if (bus.cmd_toggle) begin
        r_mode <= (r_mode == MODE_SW) ? MODE_STASH : MODE_SW;
      end
      r_next <= w_trig_stash && (r_occ != '0);
      r_wr   <= w_push;
      r_drop <= bus.cmd_sample && !w_push;
      if (w_push) r_data <= bus.time_reading;
      r_occ  <= w_occ_nxt;
      r_full <= (w_occ_nxt == FULL);
    end
  end

  assign bus.init_regs     = r_init;
  assign bus.count_enabled = r_cen;
  assign bus.split_active  = r_split;
  assign bus.stash_wr      = r_wr;
  assign bus.stash_data    = r_data;
  assign bus.stash_next    = r_next;
  assign bus.stash_full    = r_full;
  assign bus.sample_drop   = r_drop;
  assign bus.control_mode  = r_mode;
  assign bus.disp_time     = r_split ? r_snap : bus.time_reading;

endmodule
